// File: rtl/control_barrera.sv
`timescale 1ns/1ps
// Parking barrier controller: arbitrates entry/exit requests for the single
// shared barrier motor and sequences open -> hold -> close, reopening on an
// obstruction while closing. All outputs come straight from flops.
module control_barrera #(
    parameter int unsigned T_MOV     = 25_000_000,
    parameter int unsigned T_ESPERA  = 250_000_000,
    parameter int unsigned CAPACIDAD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sol_entrada,
    input  logic       sol_salida,
    input  logic       paso_entrada,
    input  logic       paso_salida,
    input  logic       obstaculo,
    input  logic [3:0] ocupados,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       concedido_entrada,
    output logic       concedido_salida,
    output logic       lleno,
    output logic       expirado,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ABRIENDO = 2'd1,
        ABIERTA  = 2'd2,
        CERRANDO = 2'd3
    } estado_t;

    // Direction of the last service; used to alternate on a tie.
    localparam logic ENTRADA = 1'b0;
    localparam logic SALIDA  = 1'b1;

    localparam int unsigned T_MAX = (T_MOV > T_ESPERA) ? T_MOV : T_ESPERA;
    localparam int          TW    = $clog2(T_MAX + 1);

    // Terminal counts: the phase ends on the cycle whose timer reads N-1.
    localparam logic [TW-1:0] FIN_MOV    = TW'(T_MOV - 1);
    localparam logic [TW-1:0] FIN_ESPERA = TW'(T_ESPERA - 1);
    localparam logic [3:0]    CAP        = 4'(CAPACIDAD);

    estado_t       state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          ultimo_q, ultimo_d;
    logic          gnt_e_q, gnt_e_d;
    logic          gnt_s_q, gnt_s_d;
    logic          abrir_q, abrir_d;
    logic          cerrar_q, cerrar_d;
    logic          lleno_q, lleno_d;
    logic          expirado_q, expirado_d;

    logic          eleg_e;
    logic          eleg_s;
    logic          paso_ok;

    // Saturating increment: the timer sticks at all-ones instead of wrapping.
    assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

    // Entry is only eligible while the live count shows a free space.
    assign eleg_e  = sol_entrada && (ocupados < CAP);
    assign eleg_s  = sol_salida;
    assign paso_ok = (gnt_e_q && paso_entrada) || (gnt_s_q && paso_salida);

    // Next-state, timer, arbitration and registered-output decode.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_inc;
        ultimo_d   = ultimo_q;
        gnt_e_d    = gnt_e_q;
        gnt_s_d    = gnt_s_q;
        expirado_d = 1'b0;

        case (state_q)
            REPOSO: begin
                timer_d = '0;
                gnt_e_d = 1'b0;
                gnt_s_d = 1'b0;
                if (eleg_e && (!eleg_s || (ultimo_q == SALIDA))) begin
                    state_d  = ABRIENDO;
                    gnt_e_d  = 1'b1;
                    ultimo_d = ENTRADA;
                end else if (eleg_s) begin
                    state_d  = ABRIENDO;
                    gnt_s_d  = 1'b1;
                    ultimo_d = SALIDA;
                end
            end
            ABRIENDO: begin
                if (timer_q >= FIN_MOV) begin
                    state_d = ABIERTA;
                    timer_d = '0;
                end
            end
            ABIERTA: begin
                // A matching pass wins over a coincident timeout.
                if (paso_ok) begin
                    state_d = CERRANDO;
                    timer_d = '0;
                end else if (timer_q >= FIN_ESPERA) begin
                    state_d    = CERRANDO;
                    timer_d    = '0;
                    expirado_d = 1'b1;
                end
            end
            CERRANDO: begin
                // An obstruction reopens fully and keeps the current grant.
                if (obstaculo) begin
                    state_d = ABRIENDO;
                    timer_d = '0;
                end else if (timer_q >= FIN_MOV) begin
                    state_d = REPOSO;
                    timer_d = '0;
                    gnt_e_d = 1'b0;
                    gnt_s_d = 1'b0;
                end
            end
            default: begin
                state_d = REPOSO;
                timer_d = '0;
                gnt_e_d = 1'b0;
                gnt_s_d = 1'b0;
            end
        endcase

        abrir_d  = (state_d == ABRIENDO);
        cerrar_d = (state_d == CERRANDO);
        lleno_d  = (ocupados >= CAP);
    end

    // State and output registers; reset stops the motor immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REPOSO;
            timer_q    <= '0;
            ultimo_q   <= SALIDA;
            gnt_e_q    <= 1'b0;
            gnt_s_q    <= 1'b0;
            abrir_q    <= 1'b0;
            cerrar_q   <= 1'b0;
            lleno_q    <= 1'b0;
            expirado_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ultimo_q   <= ultimo_d;
            gnt_e_q    <= gnt_e_d;
            gnt_s_q    <= gnt_s_d;
            abrir_q    <= abrir_d;
            cerrar_q   <= cerrar_d;
            lleno_q    <= lleno_d;
            expirado_q <= expirado_d;
        end
    end

    assign motor_abrir       = abrir_q;
    assign motor_cerrar      = cerrar_q;
    assign concedido_entrada = gnt_e_q;
    assign concedido_salida  = gnt_s_q;
    assign lleno             = lleno_q;
    assign expirado          = expirado_q;
    assign estado            = state_q;

endmodule

// File: tb/tb_control_barrera.sv
`timescale 1ns/1ps
// Bench for control_barrera: arbitration table, directed multi-cycle
// sequences and a randomized run, all checked cycle by cycle against a
// service-level reference model.
module tb_control_barrera;

    localparam int T_MOV_TB    = 4;
    localparam int T_ESPERA_TB = 10;
    localparam int CAP_TB      = 3;

    logic       clk;
    logic       rst_n;
    logic       sol_entrada, sol_salida;
    logic       paso_entrada, paso_salida;
    logic       obstaculo;
    logic [3:0] ocupados;
    logic       motor_abrir, motor_cerrar;
    logic       concedido_entrada, concedido_salida;
    logic       lleno, expirado;
    logic [1:0] estado;

    control_barrera #(
        .T_MOV    (T_MOV_TB),
        .T_ESPERA (T_ESPERA_TB),
        .CAPACIDAD(CAP_TB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sol_entrada      (sol_entrada),
        .sol_salida       (sol_salida),
        .paso_entrada     (paso_entrada),
        .paso_salida      (paso_salida),
        .obstaculo        (obstaculo),
        .ocupados         (ocupados),
        .motor_abrir      (motor_abrir),
        .motor_cerrar     (motor_cerrar),
        .concedido_entrada(concedido_entrada),
        .concedido_salida (concedido_salida),
        .lleno            (lleno),
        .expirado         (expirado),
        .estado           (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model: one service at a time ----------------
    // phase: 0 idle, 1 opening, 2 open/waiting, 3 closing; cnt = cycles done in phase
    int m_phase;
    int m_cnt;
    bit m_dir;    // 0 = entry service, 1 = exit service
    bit m_last;   // direction served last
    bit m_lleno;
    bit m_exp;

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_dir   = 1'b0;
        m_last  = 1'b1;
        m_lleno = 1'b0;
        m_exp   = 1'b0;
    endtask

    task automatic model_update();
        bit want_e, want_s;
        m_lleno = (int'(ocupados) >= CAP_TB);
        m_exp   = 1'b0;
        case (m_phase)
            0: begin
                want_e = sol_entrada && (int'(ocupados) < CAP_TB);
                want_s = sol_salida;
                if (want_e || want_s) begin
                    m_dir   = (want_e && want_s) ? !m_last : want_s;
                    m_last  = m_dir;
                    m_phase = 1;
                    m_cnt   = 0;
                end
            end
            1: begin
                m_cnt++;
                if (m_cnt == T_MOV_TB) begin m_phase = 2; m_cnt = 0; end
            end
            2: begin
                if (m_dir ? paso_salida : paso_entrada) begin
                    m_phase = 3; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == T_ESPERA_TB) begin m_phase = 3; m_cnt = 0; m_exp = 1'b1; end
                end
            end
            default: begin
                if (obstaculo) begin
                    m_phase = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == T_MOV_TB) begin m_phase = 0; m_cnt = 0; end
                end
            end
        endcase
    endtask

    // ---------------- per-cycle stepping and statistics ----------------
    int n_abrir, n_cerrar, n_exp, n_abierta, gap, min_gap, n_both;
    bit prev_g;
    int gq[$];
    int ciclo = 0;

    task automatic clr_cnt();
        n_abrir = 0; n_cerrar = 0; n_exp = 0; n_abierta = 0;
        gap = 0; min_gap = 1000; prev_g = 1'b0;
        gq.delete();
    endtask

    task automatic step();
        logic [7:0] got, want;
        @(posedge clk);
        if (rst_n) model_update(); else model_reset();
        #1;
        ciclo++;
        got  = {estado, motor_abrir, motor_cerrar, concedido_entrada, concedido_salida, lleno, expirado};
        want = {2'(m_phase), m_phase == 1, m_phase == 3,
                (m_phase != 0) && !m_dir, (m_phase != 0) && m_dir, m_lleno, m_exp};
        n_checks++;
        if (got !== want) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL modelo ciclo %0d: got %b, expected %b (estado,abrir,cerrar,ge,gs,lleno,exp)",
                         ciclo, got, want);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (motor_abrir) n_abrir++;
            if (motor_cerrar) n_cerrar++;
            if (motor_abrir && motor_cerrar) n_both++;
            if (expirado) n_exp++;
            if (estado == 2'd2) n_abierta++;
            if (estado == 2'd0) gap++;
            if ((concedido_entrada || concedido_salida) && !prev_g) begin
                gq.push_back(concedido_salida ? 1 : 0);
                if (gq.size() > 1 && gap < min_gap) min_gap = gap;
                gap = 0;
            end
            prev_g = concedido_entrada || concedido_salida;
        end
    endtask

    task automatic clear_inputs();
        sol_entrada = 0; sol_salida = 0; paso_entrada = 0; paso_salida = 0;
        obstaculo = 0; ocupados = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        check("reset_salidas",
              int'({estado, motor_abrir, motor_cerrar, concedido_entrada, concedido_salida, lleno, expirado}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_cnt();
    endtask

    // ---------------- arbitration table ----------------
    typedef struct {
        logic       se;
        logic       ss;
        logic [3:0] oc;
        logic       ge;
        logic       gs;
        logic       ll;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_both = 0;
        rst_n  = 1'b0;
        clear_inputs();
        model_reset();
        clr_cnt();

        //            se    ss    oc      ge    gs    ll
        tbl[0] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'd2,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 4'd3,  1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1};

        for (int v = 0; v < 10; v++) begin
            do_reset();
            sol_entrada = tbl[v].se;
            sol_salida  = tbl[v].ss;
            ocupados    = tbl[v].oc;
            run(1);
            $display("vector %0d: se=%0d ss=%0d oc=%0d -> ge=%0d gs=%0d lleno=%0d estado=%0d",
                     v, tbl[v].se, tbl[v].ss, tbl[v].oc, concedido_entrada, concedido_salida, lleno, estado);
            check("tabla_ge", concedido_entrada, tbl[v].ge);
            check("tabla_gs", concedido_salida, tbl[v].gs);
            check("tabla_lleno", lleno, tbl[v].ll);
            check("tabla_abrir", motor_abrir, tbl[v].ge | tbl[v].gs);
            check("tabla_estado", estado, (tbl[v].ge | tbl[v].gs) ? 1 : 0);
        end

        // Single entry, pass confirmed in the 3rd open cycle.
        do_reset();
        sol_entrada = 1;
        run(1);
        check("entrada_latencia", concedido_entrada, 1);
        sol_entrada = 0;
        run(6);
        paso_entrada = 1;
        run(1);
        paso_entrada = 0;
        run(5);
        $display("entrada simple: abrir=%0d cerrar=%0d abierta=%0d exp=%0d", n_abrir, n_cerrar, n_abierta, n_exp);
        check("entrada_abrir", n_abrir, 4);
        check("entrada_cerrar", n_cerrar, 4);
        check("entrada_abierta", n_abierta, 3);
        check("entrada_expirado", n_exp, 0);
        check("entrada_reposo", estado, 0);
        check("entrada_servicios", gq.size(), 1);

        // Tie held continuously: grants alternate.
        do_reset();
        sol_entrada = 1; sol_salida = 1; paso_entrada = 1; paso_salida = 1;
        run(40);
        clear_inputs();
        $display("empate: servicios=%0d hueco_min=%0d", gq.size(), min_gap);
        check("empate_servicios", gq.size(), 4);
        if (gq.size() == 4) begin
            check("empate_1", gq[0], 0);
            check("empate_2", gq[1], 1);
            check("empate_3", gq[2], 0);
            check("empate_4", gq[3], 1);
        end
        check("empate_hueco", min_gap, 1);

        // Lot full: entry refused, exit still served.
        do_reset();
        ocupados = 4'd3; sol_entrada = 1;
        run(1);
        check("lleno_reg", lleno, 1);
        run(50);
        $display("lleno: servicios=%0d abrir=%0d cerrar=%0d", gq.size(), n_abrir, n_cerrar);
        check("lleno_sin_servicio", gq.size(), 0);
        check("lleno_sin_motor", n_abrir + n_cerrar, 0);
        sol_salida = 1;
        run(1);
        check("lleno_salida_gs", concedido_salida, 1);
        check("lleno_salida_ge", concedido_entrada, 0);

        // Timeout with only the wrong-direction pass pulsing.
        do_reset();
        sol_entrada = 1;
        run(1);
        sol_entrada = 0;
        paso_salida = 1;
        run(13);
        check("timeout_aun_abierta", estado, 2);
        check("timeout_sin_exp", expirado, 0);
        run(1);
        check("timeout_expirado", expirado, 1);
        check("timeout_cerrando", estado, 3);
        run(1);
        check("timeout_pulso_unico", expirado, 0);
        run(3);
        paso_salida = 0;
        $display("timeout: abierta=%0d exp=%0d cerrar=%0d estado=%0d", n_abierta, n_exp, n_cerrar, estado);
        check("timeout_abierta", n_abierta, 10);
        check("timeout_cuenta_exp", n_exp, 1);
        check("timeout_reposo", estado, 0);

        // Obstruction in the 2nd closing cycle.
        begin
            int antes;
            do_reset();
            sol_entrada = 1;
            run(1);
            sol_entrada = 0;
            run(4);
            paso_entrada = 1;
            run(1);
            paso_entrada = 0;
            run(1);
            obstaculo = 1;
            antes = n_abrir;
            run(1);
            obstaculo = 0;
            check("obst_abrir", motor_abrir, 1);
            check("obst_cerrar", motor_cerrar, 0);
            check("obst_grant", concedido_entrada, 1);
            check("obst_estado", estado, 1);
            run(4);
            $display("obstaculo: reabrir=%0d estado=%0d ge=%0d", n_abrir - antes, estado, concedido_entrada);
            check("obst_reabrir", n_abrir - antes, 4);
            check("obst_abierta", estado, 2);
            check("obst_grant_abierta", concedido_entrada, 1);
            run(9);
            check("obst_timer_abierta", estado, 2);
            run(1);
            check("obst_timer_exp", expirado, 1);
            run(4);
            check("obst_reposo", estado, 0);
        end

        // Asynchronous reset in the middle of opening.
        do_reset();
        sol_entrada = 1;
        run(2);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        $display("reset asincrono: estado=%0d abrir=%0d ge=%0d", estado, motor_abrir, concedido_entrada);
        check("async_salidas",
              int'({estado, motor_abrir, motor_cerrar, concedido_entrada, concedido_salida, lleno, expirado}), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sol_entrada = 1; sol_salida = 1;
        run(1);
        check("async_empate_ge", concedido_entrada, 1);
        check("async_empate_gs", concedido_salida, 0);

        // Randomized run against the model, with occasional mid-cycle resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) sol_entrada = ~sol_entrada;
            if ($urandom_range(0, 7) == 0) sol_salida = ~sol_salida;
            paso_entrada = ($urandom_range(0, 5) == 0);
            paso_salida  = ($urandom_range(0, 5) == 0);
            obstaculo    = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) ocupados = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #3;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_async_salidas",
                      int'({estado, motor_abrir, motor_cerrar, concedido_entrada, concedido_salida, lleno, expirado}), 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            run(1);
        end
        $display("aleatorio: servicios=%0d", gq.size());
        check("motores_simultaneos", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/control_barrera.md
Name: control_barrera

Overview:
- Controller for the single-lane parking barrier. One barrier motor is shared by the entry and exit requesters.
- Arbitrates between the two debounced request lines and blocks entry when the lot is full.
- Sequences the motor open → hold → close, using the one-cycle entry/exit pulses from the direction detector as "car passed" confirmation.
- Sits between the debounce/detector/counter chain and the barrier motor driver and LEDs.

Parameters:
- T_MOV, 25_000_000, cycles the motor is driven to fully open or fully close.
- T_ESPERA, 250_000_000, max cycles the barrier stays open waiting for the car to pass.
- CAPACIDAD, 15, number of spaces; entry is refused when ocupados >= CAPACIDAD (range 1..15).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- sol_entrada  in  1  entry request level (debounced, synchronous to clk).
- sol_salida  in  1  exit request level (debounced, synchronous to clk).
- paso_entrada  in  1  one-cycle pulse: detector confirmed a car entered.
- paso_salida  in  1  one-cycle pulse: detector confirmed a car exited.
- obstaculo  in  1  barrier-path obstruction sensor, level, synchronous.
- ocupados  in  4  current car count from the counter (unsigned).
- motor_abrir  out  1  drive motor open direction.
- motor_cerrar  out  1  drive motor close direction.
- concedido_entrada  out  1  entry grant, held for the whole cycle of service.
- concedido_salida  out  1  exit grant, held for the whole cycle of service.
- lleno  out  1  lot full (ocupados >= CAPACIDAD), registered.
- expirado  out  1  one-cycle pulse: open phase ended by timeout.
- estado  out  2  current FSM state, for debug LEDs.

Behaviour:
Reset (rst_n=0, asynchronous):
- State is REPOSO; all outputs are 0.
- Timer is 0.
- ultimo is SALIDA, so entry wins the first tie.

General:
- All outputs are registered.
- motor_abrir and motor_cerrar are never 1 in the same cycle.
- Exactly one grant is high in every state except REPOSO, where both are 0.

States (estado encoding):
- REPOSO (0):
  - Eligible entry = sol_entrada && (ocupados < CAPACIDAD), evaluated on the live ocupados input.
  - Eligible exit = sol_salida.
  - If exactly one is eligible, grant it. If both are eligible, grant the direction opposite to ultimo.
  - On a grant: update ultimo, clear the timer, and go to ABRIENDO. The grant and motor_abrir are high in the next cycle (1-cycle latency).
  - With no eligible request, stay in REPOSO.
- ABRIENDO (1):
  - motor_abrir=1.
  - After exactly T_MOV cycles in this state, clear the timer and go to ABIERTA.
- ABIERTA (2):
  - Motor off.
  - A paso pulse matching the granted direction → CERRANDO in the next cycle.
  - A paso pulse for the other direction is ignored.
  - If T_ESPERA cycles elapse without a matching pulse → CERRANDO, with expirado=1 for one cycle.
  - If a matching pulse and the timeout coincide, the pulse wins and expirado stays 0.
- CERRANDO (3):
  - motor_cerrar=1 for exactly T_MOV cycles, then go to REPOSO and drop the grant.
  - If obstaculo=1 in any CERRANDO cycle: in the next cycle go to ABRIENDO (full T_MOV reopen) with the grant kept; motor_cerrar drops and motor_abrir rises in the same cycle.
  - obstaculo is ignored in all other states.

Arithmetic and width rules:
- Timer is an unsigned counter wide enough for max(T_MOV, T_ESPERA); it saturates and never wraps.
- lleno updates every cycle: ocupados >= CAPACIDAD is registered into lleno.

Request handling:
- Requests are level-sensitive.
- A request still held at return to REPOSO is re-arbitrated that same REPOSO cycle.
- REPOSO lasts a minimum of 1 cycle between services.
- Requests that arrive while not in REPOSO are not queued; the level is seen on return.

Reset mid-operation:
- Asserting rst_n at any point stops the motor immediately and returns to REPOSO.

Test Plan:
- Bench parameters: T_MOV=4, T_ESPERA=10, CAPACIDAD=3.
- Single entry: sol_entrada=1, ocupados=0, pulse paso_entrada in the 3rd ABIERTA cycle → concedido_entrada high at N+1; motor_abrir high 4 cycles; motor_cerrar high 4 cycles; return to REPOSO; expirado never set.
- Tie and fairness: sol_entrada=sol_salida=1 held continuously, passes confirmed each time → grants alternate entrada, salida, entrada, with ≥1 REPOSO cycle between them.
- Lot full: ocupados=3, sol_entrada=1, sol_salida=0 → lleno=1 after 1 cycle; no grant and no motor activity for 50 cycles. Then raise sol_salida → exit granted.
- Timeout and wrong pulse: entry granted, only paso_salida pulsed in ABIERTA → ignored; after 10 cycles expirado=1 for one cycle, then closes normally.
- Obstruction: obstaculo=1 in the 2nd CERRANDO cycle → next cycle motor_abrir=1 (4 cycles), ABIERTA entered again with the same grant still high, timer restarted.
- Async reset: assert rst_n=0 mid-ABRIENDO between clock edges → all outputs 0 immediately, estado=0. After release, a tie goes to entry first.
